// File: rtl/bsg_profiler_counter_bank.sv
`default_nettype none
// ============================================================================
// Module : bsg_profiler_counter_bank
// Brief  : Saturating per-client event counters with snapshot and streamed
//          (index, count) dump over a valid/yumi handshake.
// Rev    : 1.0  initial release
// ============================================================================
module bsg_profiler_counter_bank #(
  parameter int                 els_p         = 32,
  parameter int                 width_p       = 32,
  parameter logic [els_p-1:0]   enable_mask_p = {els_p{1'b1}},
  localparam int                lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [els_p-1:0]      countme_i,
  input  logic                  clear_i,
  input  logic                  dump_i,
  output logic                  dump_busy_o,
  output logic                  dump_v_o,
  output logic [lg_els_lp-1:0]  dump_idx_o,
  output logic [width_p-1:0]    dump_count_o,
  input  logic                  dump_yumi_i,
  output logic                  dump_done_o
);

  localparam logic [1:0] c_state_idle   = 2'd0;
  localparam logic [1:0] c_state_stream = 2'd1;
  localparam logic [1:0] c_state_done   = 2'd2;

  localparam logic [lg_els_lp-1:0] c_last_idx = lg_els_lp'(els_p - 1);
  localparam logic [width_p-1:0]   c_cnt_max  = {width_p{1'b1}};

  logic [1:0]            r_state;
  logic [lg_els_lp-1:0]  r_idx;
  logic [width_p-1:0]    r_cnt  [els_p];
  logic [width_p-1:0]    r_snap [els_p];
  logic                  w_accept;

  assign w_accept = (r_state == c_state_idle) && dump_i;

  // Clear outranks a same-cycle increment; masked-off counters are pinned at 0.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (reset_i || clear_i || !enable_mask_p[i]) begin
        r_cnt[i] <= '0;
      end else if (countme_i[i] && (r_cnt[i] != c_cnt_max)) begin
        r_cnt[i] <= r_cnt[i] + width_p'(1);
      end
    end
  end

  // Snapshot takes the pre-edge count, so the accepting cycle's events are excluded.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (reset_i) begin
        r_snap[i] <= '0;
      end else if (w_accept) begin
        r_snap[i] <= r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= c_state_idle;
      r_idx   <= '0;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (dump_i) begin
            r_state <= c_state_stream;
            r_idx   <= '0;
          end
        end
        c_state_stream: begin
          if (dump_yumi_i) begin
            if (r_idx == c_last_idx) begin
              r_state <= c_state_done;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + lg_els_lp'(1);
            end
          end
        end
        c_state_done: begin
          r_state <= c_state_idle;
        end
        default: begin
          r_state <= c_state_idle;
        end
      endcase
    end
  end

  assign dump_busy_o  = (r_state != c_state_idle);
  assign dump_v_o     = (r_state == c_state_stream);
  assign dump_done_o  = (r_state == c_state_done);
  assign dump_idx_o   = r_idx;
  assign dump_count_o = r_snap[r_idx];

endmodule
`default_nettype wire

// File: tb/tb_bsg_profiler_counter_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_bsg_profiler_counter_bank
// Brief  : Randomized scoreboard bench for two counter-bank configurations
//          (32x32 full mask, 4x4 partial mask) sharing one stimulus stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bsg_profiler_counter_bank;

  localparam int N0 = 32, W0 = 32;
  localparam int N1 = 4,  W1 = 4;
  localparam logic [3:0] MASK1 = 4'b1011;

  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0, dump = 1'b0;
  logic [31:0] countme = '0;
  logic [1:0]  yumi = '0;

  logic        busy0, v0, done0, busy1, v1, done1;
  logic [4:0]  idx0;
  logic [31:0] cnt0;
  logic [1:0]  idx1;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  bsg_profiler_counter_bank #(.els_p(N0), .width_p(W0)) dut0 (
    .clk_i(clk), .reset_i(reset), .countme_i(countme), .clear_i(clear),
    .dump_i(dump), .dump_busy_o(busy0), .dump_v_o(v0), .dump_idx_o(idx0),
    .dump_count_o(cnt0), .dump_yumi_i(yumi[0]), .dump_done_o(done0));

  bsg_profiler_counter_bank #(.els_p(N1), .width_p(W1), .enable_mask_p(MASK1)) dut1 (
    .clk_i(clk), .reset_i(reset), .countme_i(countme[3:0]), .clear_i(clear),
    .dump_i(dump), .dump_busy_o(busy1), .dump_v_o(v1), .dump_idx_o(idx1),
    .dump_count_o(cnt1), .dump_yumi_i(yumi[1]), .dump_done_o(done1));

  typedef struct { int idx; longint unsigned cnt; } ent_t;
  typedef struct { bit busy; bit v; bit done; } flg_t;

  ent_t eq [2][$];
  flg_t fq [2][$];
  longint unsigned mc [2][32];
  int  mrem  [2];
  bit  mdone [2];
  int  tests = 0, fails = 0;

  function automatic int nels(int k);
    return (k == 0) ? N0 : N1;
  endfunction

  function automatic longint unsigned cmax(int k);
    return (k == 0) ? ((64'd1 << W0) - 1) : ((64'd1 << W1) - 1);
  endfunction

  function automatic bit enabled(int k, int i);
    return (k == 0) ? 1'b1 : MASK1[i];
  endfunction

  function automatic bit idle(int k);
    return (mrem[k] == 0) && !mdone[k];
  endfunction

  // One clock of stimulus; the model advances to the state after the coming edge.
  // ymode: 0 none, 1 yumi whenever valid, 2 random while valid, 3 random always.
  task automatic cyc(input logic [31:0] cm, input bit clr, input bit dmp,
                     input bit rst, input int ymode);
    logic [1:0] y;
    for (int k = 0; k < 2; k++) begin
      case (ymode)
        1:       y[k] = (mrem[k] > 0);
        2:       y[k] = (mrem[k] > 0) && $urandom_range(1, 0) == 1;
        3:       y[k] = $urandom_range(1, 0) == 1;
        default: y[k] = 1'b0;
      endcase
      if (rst) y[k] = 1'b0;
    end
    countme = cm; clear = clr; dump = dmp; reset = rst; yumi = y;
    for (int k = 0; k < 2; k++) begin
      flg_t f;
      bit acc, nd, was_idle;
      f.busy = !idle(k); f.v = (mrem[k] > 0); f.done = mdone[k];
      fq[k].push_back(f);
      if (rst) begin
        mrem[k] = 0; mdone[k] = 0; eq[k].delete();
        for (int i = 0; i < 32; i++) mc[k][i] = 0;
      end else begin
        was_idle = idle(k);
        acc = y[k] && (mrem[k] > 0);
        nd  = acc && (mrem[k] == 1);
        if (acc) mrem[k]--;
        if (was_idle && dmp) begin
          for (int i = 0; i < nels(k); i++) begin
            ent_t e; e.idx = i; e.cnt = mc[k][i];
            eq[k].push_back(e);
          end
          mrem[k] = nels(k);
        end
        mdone[k] = nd;
        for (int i = 0; i < nels(k); i++) begin
          if (clr) mc[k][i] = 0;
          else if (cm[i] && enabled(k, i) && mc[k][i] < cmax(k)) mc[k][i]++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input logic [31:0] cm, input int ymode);
    int n = 0;
    while (!(idle(0) && idle(1)) && n < 300) begin
      cyc(cm, 0, 0, 0, ymode);
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain_timeout: model still busy after %0d cycles, required idle", n);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ob, ov, od;
      int oi;
      longint unsigned oc;
      ob = (k == 0) ? busy0 : busy1;
      ov = (k == 0) ? v0 : v1;
      od = (k == 0) ? done0 : done1;
      oi = (k == 0) ? int'(idx0) : int'(idx1);
      oc = (k == 0) ? longint'(cnt0) : longint'(cnt1);
      if (fq[k].size() > 0) begin
        flg_t f;
        f = fq[k].pop_front();
        tests++;
        if (ob !== f.busy || ov !== f.v || od !== f.done) begin
          fails++;
          $display("FAIL flags[%0d] t=%0t: busy/v/done got %b%b%b, required %b%b%b",
                   k, $time, ob, ov, od, f.busy, f.v, f.done);
        end
      end
      if (ov === 1'b1 && yumi[k] === 1'b1) begin
        tests++;
        if (eq[k].size() == 0) begin
          fails++;
          $display("FAIL entry[%0d] t=%0t: unexpected entry idx %0d count %0d, required none",
                   k, $time, oi, oc);
        end else begin
          ent_t e;
          e = eq[k].pop_front();
          if (oi != e.idx || oc != e.cnt) begin
            fails++;
            $display("FAIL entry[%0d] t=%0t: got idx %0d count %0d, required idx %0d count %0d",
                     k, $time, oi, oc, e.idx, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      mrem[k] = 0; mdone[k] = 0;
      for (int i = 0; i < 32; i++) mc[k][i] = 0;
    end
    @(posedge clk); #1;
    // reset, idle, then dump of an all-zero bank
    repeat (8) cyc(0, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    drain(0, 1);
    // single busy counter, full-rate dump (done 33 cycles after request)
    repeat (7) cyc(32'h20, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    drain(0, 1);
    // dump-then-clear each time idle while counter 3 ticks every cycle
    repeat (4) begin
      cyc(32'h8, 1, 1, 0, 2);
      drain(32'h8, 2);
      repeat ($urandom_range(3, 0)) cyc(32'h8, 0, 0, 0, 0);
    end
    // clear beats same-cycle increment
    cyc(32'h1, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    drain(0, 1);
    // saturation on the narrow bank
    repeat (20) cyc(32'h2, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    drain(0, 1);
    // stalling consumer with a second request mid-stream
    cyc($urandom, 0, 1, 0, 2);
    repeat (10) cyc($urandom, 0, 0, 0, 2);
    cyc($urandom, 0, 1, 0, 2);
    drain(0, 2);
    // reset mid-dump
    cyc($urandom, 0, 1, 0, 1);
    repeat (6) cyc($urandom, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    // free-running random traffic
    repeat (600) cyc($urandom, $urandom_range(7, 0) == 0, $urandom_range(5, 0) == 0,
                     $urandom_range(96, 0) == 0, 3);
    drain(0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (eq[k].size() != 0) begin
        fails++;
        $display("FAIL leftover[%0d]: %0d entries never delivered, required 0", k, eq[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
